alu_pipe: RTL
=============

// Module: alu_pipe
// PURPOSE
//  Parametrised, handshaked successor to the 8-bit combinational ALU.
//  Takes operands and an opcode through a valid/ready input port, computes in
//  one cycle (logic/add/sub/shift) or WIDTH cycles (iterative multiply), and
//  returns a registered result plus Z/N/C/V flags on a valid/ready output port.
//  Sits between operand fetch and writeback in the datapath.
// PARAMETERS
//  WIDTH   8   operand/result width in bits; legal range 2..32
//  SHW     $clog2(WIDTH)   derived (localparam); shift-amount bits taken from b
// PORTS
//  clk        in   1      single clock, rising edge
//  reset_n    in   1      asynchronous, active-low reset
//  in_valid   in   1      operands/op presented
//  in_ready   out  1      block can accept this cycle
//  a          in   WIDTH  operand A (signed)
//  b          in   WIDTH  operand B (signed)
//  op         in   3      000 AND, 001 OR, 010 ADD, 011 SUB, 100 XOR,
//                         101 SLL, 110 SRA, 111 MUL (unsigned, low half)
//  out_valid  out  1      result/flags valid
//  out_ready  in   1      consumer takes result this cycle
//  result     out  WIDTH  registered result
//  flag_z     out  1      result == 0
//  flag_n     out  1      result[WIDTH-1]
//  flag_c     out  1      ADD carry-out; SUB borrow (a<b unsigned); MUL upper half !=0; else 0
//  flag_v     out  1      signed overflow for ADD/SUB; else 0
// BEHAVIOUR
//  - Reset (reset_n=0, async): state IDLE, out_valid=0, result=0, all flags=0,
//    multiply counter/accumulator cleared. Reset mid-MUL aborts; no result emitted.
//  - FSM states: IDLE, BUSY (multiply iterating), HOLD (result presented).
//  - in_ready = (state==IDLE) | (state==HOLD & out_ready). Accept = in_valid & in_ready;
//    operands/op captured at the accepting edge; inputs are don't-care otherwise.
//  - Single-cycle op accepted: HOLD with out_valid=1 on the next cycle (latency 1).
//    Back-to-back accepts in HOLD with out_ready=1 give one result per cycle.
//  - MUL accepted: BUSY; one shift-add step per edge over 2*WIDTH-bit accumulator;
//    after WIDTH BUSY edges go HOLD. out_valid rises WIDTH+1 cycles after accept.
//    in_ready=0 and out_valid=0 throughout BUSY.
//  - HOLD: result and flags held stable while out_ready=0. out_valid&out_ready with
//    no new accept -> IDLE, out_valid=0 next cycle. Result reg keeps last value.
//  - Arithmetic: ADD/SUB computed in WIDTH+1 bits; result = low WIDTH bits.
//    V(ADD)=a,b same sign & result sign differs; V(SUB)=a,b signs differ & result
//    sign != a sign. SLL/SRA amount = b[SHW-1:0]; SRA replicates a[WIDTH-1].
//    Amount >= WIDTH (non-power-of-2 WIDTH): SLL -> 0, SRA -> all sign bits.
//  - Flags update only when the corresponding result is loaded; Z/N from result.
//  - WIDTH=8 with op[2]=0 matches the legacy ALU encoding/results exactly.
// TESTING (WIDTH=8 unless noted)
//  - ADD 8'h7F+8'h01, out_ready=1 -> out_valid 1 cycle after accept, result 8'h80,
//    N=1 V=1 C=0 Z=0; ADD 8'hFF+8'h01 -> 8'h00, Z=1 C=1 V=0.
//  - SUB 8'h05-8'h05 -> 8'h00 Z=1 C=0; SUB 8'h00-8'h01 -> 8'hFF N=1 C=1 V=0;
//    SRA 8'h80 by 3 -> 8'hF0; SLL 8'h81 by 1 -> 8'h02.
//  - MUL 20*13 -> result 8'h04, C=1, out_valid exactly 9 cycles after accept,
//    in_ready=0 during BUSY; MUL 15*15 -> 8'hE1, C=0.
//  - Stream AND/OR/XOR with in_valid=1, out_ready=1 -> one in-order result per cycle,
//    in_ready never drops; compare against reference model.
//  - Hold out_ready=0 for 5 cycles after a result -> result/flags stable, in_ready=0,
//    pending input not accepted; release -> accepted next edge.
//  - Assert reset_n=0 on 4th BUSY cycle of a MUL -> out_valid=0, result=0 at once;
//    after release in_ready=1 and no stale result ever appears.

Source files
------------

// File: rtl/alu_pipe_if.sv
// alu_pipe_if: valid/ready operand port (in_valid/in_ready/a/b/op) and result port (out_valid/out_ready/result/flag_z/n/c/v) of alu_pipe
interface alu_pipe_if #(parameter int WIDTH = 8);
  logic in_valid;
  logic in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [2:0] op;
  logic out_valid;
  logic out_ready;
  logic [WIDTH-1:0] result;
  logic flag_z;
  logic flag_n;
  logic flag_c;
  logic flag_v;
  modport master (
    output in_valid, a, b, op, out_ready,
    input in_ready, out_valid, result, flag_z, flag_n, flag_c, flag_v
  );
  modport slave (
    input in_valid, a, b, op, out_ready,
    output in_ready, out_valid, result, flag_z, flag_n, flag_c, flag_v
  );
endinterface

// File: rtl/alu_pipe.sv
// alu_pipe: handshaked ALU, 1-cycle logic/add/sub/shift and WIDTH-cycle shift-add MUL; ports clk, reset_n (async low), bus (slave alu_pipe_if)
module alu_pipe #(
  parameter int WIDTH = 8
) (
  input logic clk,
  input logic reset_n,
  alu_pipe_if.slave bus
);
  localparam int SHW = $clog2(WIDTH);
  typedef enum logic [1:0] {IDLE, BUSY, HOLD} state_t;
  state_t state;
  logic [WIDTH-1:0] res;
  logic z, n, c, v;
  logic [2*WIDTH-1:0] acc, mcand, acc_nx;
  logic [WIDTH-1:0] mplier;
  logic [SHW-1:0] cnt;
  logic [WIDTH:0] sum, diff;
  logic [WIDTH-1:0] alu_r, sra_r;
  logic [SHW-1:0] amt;
  logic alu_c, alu_v, accept, last;
  assign bus.in_ready = (state == IDLE) || (state == HOLD && bus.out_ready);
  assign bus.out_valid = state == HOLD;
  assign bus.result = res;
  assign bus.flag_z = z;
  assign bus.flag_n = n;
  assign bus.flag_c = c;
  assign bus.flag_v = v;
  assign accept = bus.in_valid && bus.in_ready;
  assign last = cnt == SHW'(WIDTH - 1);
  always_comb begin
    sum = {1'b0, bus.a} + {1'b0, bus.b};
    diff = {1'b0, bus.a} - {1'b0, bus.b};
    amt = bus.b[SHW-1:0];
    sra_r = $signed(bus.a) >>> amt;
    alu_r = bus.op == 3'd0 ? bus.a & bus.b :
            bus.op == 3'd1 ? bus.a | bus.b :
            bus.op == 3'd2 ? sum[WIDTH-1:0] :
            bus.op == 3'd3 ? diff[WIDTH-1:0] :
            bus.op == 3'd4 ? bus.a ^ bus.b :
            bus.op == 3'd5 ? bus.a << amt : sra_r;
    alu_c = bus.op == 3'd2 ? sum[WIDTH] : bus.op == 3'd3 ? diff[WIDTH] : 1'b0;
    alu_v = bus.op == 3'd2 ? (bus.a[WIDTH-1] == bus.b[WIDTH-1]) && (sum[WIDTH-1] != bus.a[WIDTH-1]) :
            bus.op == 3'd3 ? (bus.a[WIDTH-1] != bus.b[WIDTH-1]) && (diff[WIDTH-1] != bus.a[WIDTH-1]) : 1'b0;
    acc_nx = acc + (mplier[0] ? mcand : '0);
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      res <= '0;
      z <= 1'b0;
      n <= 1'b0;
      c <= 1'b0;
      v <= 1'b0;
      acc <= '0;
      mcand <= '0;
      mplier <= '0;
      cnt <= '0;
    end else if (accept) begin
      if (bus.op == 3'd7) begin
        state <= BUSY;
        acc <= '0;
        mcand <= {{WIDTH{1'b0}}, bus.a};
        mplier <= bus.b;
        cnt <= '0;
      end else begin
        state <= HOLD;
        res <= alu_r;
        z <= alu_r == '0;
        n <= alu_r[WIDTH-1];
        c <= alu_c;
        v <= alu_v;
      end
    end else if (state == BUSY) begin
      acc <= acc_nx;
      mcand <= mcand << 1;
      mplier <= mplier >> 1;
      cnt <= cnt + SHW'(1);
      if (last) begin
        state <= HOLD;
        res <= acc_nx[WIDTH-1:0];
        z <= acc_nx[WIDTH-1:0] == '0;
        n <= acc_nx[WIDTH-1];
        c <= |acc_nx[2*WIDTH-1:WIDTH];
        v <= 1'b0;
      end
    end else if (state == HOLD && bus.out_ready) begin
      state <= IDLE;
    end
  end
endmodule
